// File: rtl/demux_8_stream_if.sv
// ============================================================================
//  demux_8_stream_if
//  Bundle of the single input channel and eight output channels for
//  demux_8_stream. Build macro: DEMUX_8_STREAM_PKT_LOCK_EN adds last_i/last_o.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface demux_8_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic [2:0]            select_i;
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] data_0_o;
    logic [DATA_WIDTH-1:0] data_1_o;
    logic [DATA_WIDTH-1:0] data_2_o;
    logic [DATA_WIDTH-1:0] data_3_o;
    logic [DATA_WIDTH-1:0] data_4_o;
    logic [DATA_WIDTH-1:0] data_5_o;
    logic [DATA_WIDTH-1:0] data_6_o;
    logic [DATA_WIDTH-1:0] data_7_o;
    logic [7:0]            valid_o;
    logic [7:0]            ready_i;
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
    logic                  last_i;
    logic [7:0]            last_o;
`endif

    // Environment side: producer plus the eight consumers.
    modport master (
        output data_i, select_i, valid_i, ready_i,
        input  ready_o, valid_o,
        input  data_0_o, data_1_o, data_2_o, data_3_o,
        input  data_4_o, data_5_o, data_6_o, data_7_o
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
        , output last_i, input last_o
`endif
    );

    // Demultiplexer side.
    modport slave (
        input  data_i, select_i, valid_i, ready_i,
        output ready_o, valid_o,
        output data_0_o, data_1_o, data_2_o, data_3_o,
        output data_4_o, data_5_o, data_6_o, data_7_o
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
        , input last_i, output last_o
`endif
    );
endinterface

`default_nettype wire

// File: rtl/demux_8_stream.sv
// ============================================================================
//  demux_8_stream
//  1-to-8 valid/ready stream demux with one registered holding stage.
//  Build macro: DEMUX_8_STREAM_PKT_LOCK_EN enables packet-locked routing.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module demux_8_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    demux_8_stream_if.slave  bus
);
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            sel_q, sel_d;
    logic                  full_q, full_d;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_pop;
    logic [2:0]            w_route_sel;
    logic [7:0]            w_valid;
    logic [DATA_WIDTH-1:0] w_data_out [8];

`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] lock_sel_q, lock_sel_d;
    logic       last_q, last_d;

    // Mid-packet beats ignore select_i and follow the first beat's channel.
    assign w_route_sel = (state_q == c_st_locked) ? lock_sel_q : bus.select_i;
`else
    assign w_route_sel = bus.select_i;
`endif

    // ready depends only on held state and the selected consumer, never on valid_i.
    assign w_pop     = full_q & bus.ready_i[sel_q];
    assign w_ready   = ~rst_i & (~full_q | bus.ready_i[sel_q]);
    assign w_accept  = bus.valid_i & w_ready;
    assign bus.ready_o = w_ready;

    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        full_d = full_q;
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
        last_d     = last_q;
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
`endif
        if (w_accept) begin
            data_d = bus.data_i;
            sel_d  = w_route_sel;
            full_d = 1'b1;
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
            last_d = bus.last_i;
            if (state_q == c_st_idle) begin
                if (!bus.last_i) begin
                    state_d    = c_st_locked;
                    lock_sel_d = bus.select_i;
                end
            end else if (bus.last_i) begin
                state_d = c_st_idle;
            end
`endif
        end else if (w_pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            sel_q  <= '0;
            full_q <= 1'b0;
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
            last_q     <= 1'b0;
            state_q    <= c_st_idle;
            lock_sel_q <= '0;
`endif
        end else begin
            data_q <= data_d;
            sel_q  <= sel_d;
            full_q <= full_d;
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
            last_q     <= last_d;
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
`endif
        end
    end

    generate
        for (genvar k = 0; k < 8; k++) begin : g_out
            assign w_valid[k]    = full_q & (sel_q == 3'(k));
            assign w_data_out[k] = w_valid[k] ? data_q : '0;
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
            assign bus.last_o[k] = w_valid[k] & last_q;
`endif
        end
    endgenerate

    assign bus.valid_o  = w_valid;
    assign bus.data_0_o = w_data_out[0];
    assign bus.data_1_o = w_data_out[1];
    assign bus.data_2_o = w_data_out[2];
    assign bus.data_3_o = w_data_out[3];
    assign bus.data_4_o = w_data_out[4];
    assign bus.data_5_o = w_data_out[5];
    assign bus.data_6_o = w_data_out[6];
    assign bus.data_7_o = w_data_out[7];
endmodule

`default_nettype wire

// File: tb/tb_demux_8_stream.sv
// ============================================================================
//  tb_demux_8_stream
//  Directed self-checking bench for demux_8_stream.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux_8_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    demux_8_stream_if #(.DATA_WIDTH(8)) bus ();

    demux_8_stream #(.DATA_WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chan_data(input int k);
        case (k)
            0: return bus.data_0_o;
            1: return bus.data_1_o;
            2: return bus.data_2_o;
            3: return bus.data_3_o;
            4: return bus.data_4_o;
            5: return bus.data_5_o;
            6: return bus.data_6_o;
            default: return bus.data_7_o;
        endcase
    endfunction

    task automatic set_beat(input logic v, input logic [2:0] s, input logic [7:0] d);
        bus.valid_i  = v;
        bus.select_i = s;
        bus.data_i   = d;
    endtask

    // Checks every data output: channel ch must carry d, all others zero.
    task automatic check_data(input string name, input int ch, input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] exp;
            exp = (k == ch) ? d : 8'h00;
            n_vec++;
            if (chan_data(k) !== exp) begin
                n_err++;
                $display("FAIL %s data_%0d_o: got %h expected %h", name, k, chan_data(k), exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_beat(1'b0, 3'd0, 8'h00);
        bus.ready_i = 8'hFF;
        tick();
        tick();
        n_vec++;
        if (bus.ready_o !== 1'b0) begin
            n_err++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
        end
        n_vec++;
        if (bus.valid_o !== 8'h00) begin
            n_err++; $display("FAIL reset_valid: got %h expected 00", bus.valid_o);
        end
        check_data("reset", -1, 8'h00);
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL idle_ready: got %b expected 1", bus.ready_o);
        end
    endtask

    task automatic test_single_beat();
        bus.ready_i = 8'hFF;
        set_beat(1'b1, 3'd5, 8'hA5);
        tick();
        n_vec++;
        if (bus.valid_o !== 8'h20) begin
            n_err++; $display("FAIL single_valid: got %h expected 20", bus.valid_o);
        end
        check_data("single", 5, 8'hA5);
        n_vec++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL single_ready: got %b expected 1", bus.ready_o);
        end
        set_beat(1'b0, 3'd0, 8'h00);
        tick();
        n_vec++;
        if (bus.valid_o !== 8'h00) begin
            n_err++; $display("FAIL single_drain: got %h expected 00", bus.valid_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.ready_i = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            set_beat(1'b1, 3'(k), 8'h10 + 8'(k));
            #1;
            n_vec++;
            if (bus.ready_o !== 1'b1) begin
                n_err++; $display("FAIL b2b_ready beat %0d: got %b expected 1", k, bus.ready_o);
            end
            tick();
            n_vec++;
            if (bus.valid_o !== (8'h01 << k)) begin
                n_err++; $display("FAIL b2b_valid beat %0d: got %h expected %h", k, bus.valid_o, 8'h01 << k);
            end
            check_data("b2b", k, 8'h10 + 8'(k));
        end
        set_beat(1'b0, 3'd0, 8'h00);
        tick();
        n_vec++;
        if (bus.valid_o !== 8'h00) begin
            n_err++; $display("FAIL b2b_drain: got %h expected 00", bus.valid_o);
        end
    endtask

    task automatic test_backpressure();
        bus.ready_i = 8'hF7;
        set_beat(1'b1, 3'd3, 8'h33);
        tick();
        set_beat(1'b1, 3'd6, 8'h66);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (bus.ready_o !== 1'b0) begin
                n_err++; $display("FAIL bp_ready cycle %0d: got %b expected 0", c, bus.ready_o);
            end
            n_vec++;
            if (bus.valid_o !== 8'h08) begin
                n_err++; $display("FAIL bp_valid cycle %0d: got %h expected 08", c, bus.valid_o);
            end
            n_vec++;
            if (bus.data_3_o !== 8'h33) begin
                n_err++; $display("FAIL bp_data3 cycle %0d: got %h expected 33", c, bus.data_3_o);
            end
            tick();
        end
        bus.ready_i = 8'hFF;
        #1;
        n_vec++;
        if (bus.ready_o !== 1'b1) begin
            n_err++; $display("FAIL bp_release_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        n_vec++;
        if (bus.valid_o !== 8'h40) begin
            n_err++; $display("FAIL bp_swap_valid: got %h expected 40", bus.valid_o);
        end
        check_data("bp_swap", 6, 8'h66);
        set_beat(1'b0, 3'd0, 8'h00);
        tick();
        n_vec++;
        if (bus.valid_o !== 8'h00) begin
            n_err++; $display("FAIL bp_drain: got %h expected 00", bus.valid_o);
        end
    endtask

    task automatic test_ignore_other_ready();
        bus.ready_i = 8'hFB;
        set_beat(1'b1, 3'd2, 8'h22);
        tick();
        set_beat(1'b1, 3'd1, 8'h11);
        for (int c = 0; c < 4; c++) begin
            bus.ready_i = c[0] ? 8'hBB : 8'hFB;
            #1;
            n_vec++;
            if (bus.ready_o !== 1'b0) begin
                n_err++; $display("FAIL hold_ready cycle %0d: got %b expected 0", c, bus.ready_o);
            end
            tick();
            n_vec++;
            if ({bus.valid_o, bus.data_2_o} !== {8'h04, 8'h22}) begin
                n_err++; $display("FAIL hold_state cycle %0d: got %h/%h expected 04/22", c, bus.valid_o, bus.data_2_o);
            end
        end
        // Drain with valid_i low and an undefined select: nothing must load.
        bus.ready_i = 8'hFF;
        set_beat(1'b0, 3'bxxx, 8'hEE);
        tick();
        tick();
        n_vec++;
        if ({bus.valid_o, bus.ready_o} !== {8'h00, 1'b1}) begin
            n_err++; $display("FAIL idle_no_load: got %h/%b expected 00/1", bus.valid_o, bus.ready_o);
        end
    endtask

    task automatic test_reset_while_full();
        bus.ready_i = 8'hEF;
        set_beat(1'b1, 3'd4, 8'h44);
        tick();
        set_beat(1'b0, 3'd0, 8'h00);
        n_vec++;
        if (bus.valid_o !== 8'h10) begin
            n_err++; $display("FAIL rstfull_pre: got %h expected 10", bus.valid_o);
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if ({bus.valid_o, bus.data_4_o, bus.ready_o} !== {8'h00, 8'h00, 1'b0}) begin
            n_err++; $display("FAIL rstfull_clear: got %h/%h/%b expected 00/00/0", bus.valid_o, bus.data_4_o, bus.ready_o);
        end
        rst = 1'b0;
        bus.ready_i = 8'hFF;
        set_beat(1'b1, 3'd7, 8'h77);
        tick();
        n_vec++;
        if (bus.valid_o !== 8'h80) begin
            n_err++; $display("FAIL rstfull_fresh_valid: got %h expected 80", bus.valid_o);
        end
        check_data("rstfull_fresh", 7, 8'h77);
        set_beat(1'b0, 3'd0, 8'h00);
        tick();
    endtask

`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [2:0]  s_tab [4] = '{3'd1, 3'd6, 3'd7, 3'd6};
        logic        l_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0]  d_tab [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hB6};
        int          c_tab [4] = '{1, 1, 1, 6};
        logic [7:0]  lo_tab[4] = '{8'h00, 8'h00, 8'h02, 8'h40};
        bus.ready_i = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            set_beat(1'b1, s_tab[b], d_tab[b]);
            bus.last_i = l_tab[b];
            tick();
            n_vec++;
            if (bus.valid_o !== (8'h01 << c_tab[b])) begin
                n_err++; $display("FAIL pkt_valid beat %0d: got %h expected %h", b, bus.valid_o, 8'h01 << c_tab[b]);
            end
            n_vec++;
            if (bus.last_o !== lo_tab[b]) begin
                n_err++; $display("FAIL pkt_last beat %0d: got %h expected %h", b, bus.last_o, lo_tab[b]);
            end
            check_data("pkt", c_tab[b], d_tab[b]);
        end
        set_beat(1'b0, 3'd0, 8'h00);
        bus.last_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        bus.ready_i = 8'hFF;
        set_beat(1'b0, 3'd0, 8'h00);
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
        bus.last_i = 1'b0;
`endif
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_ignore_other_ready();
        test_reset_while_full();
`ifdef DEMUX_8_STREAM_PKT_LOCK_EN
        test_pkt_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/demux_8_stream.md
Name: demux_8_stream

Overview:
- 1-to-8 stream demultiplexer with a valid/ready handshake and one registered output stage.
- Each beat accepted on the single input channel is routed to exactly one of eight output channels, chosen by select_i sampled with the beat.
- Used wherever one producer feeds up to eight consumers, for example command dispatch to eight engines.

Parameters:
DATA_WIDTH, 8, width of the data on the input channel and on each output channel.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
rst_i  input  1  reset, synchronous, active-high.
data_i  input  DATA_WIDTH  input beat data.
select_i  input  3  destination channel index (0..7), sampled with the beat.
valid_i  input  1  input beat valid.
ready_o  output  1  input beat accepted when valid_i & ready_o.
data_0_o .. data_7_o  output  DATA_WIDTH each  per-channel output data.
valid_o  output  8  bit k is the valid for channel k.
ready_i  input  8  bit k is the ready from channel k.

Behaviour:
- State:
  - holding register data_r (DATA_WIDTH), sel_r (3 bits), full_r (1 bit).
- Reset (rst_i=1 at a clock edge):
  - full_r=0, sel_r=0, data_r=0.
  - valid_o=8'h00, all data_k_o=0.
  - ready_o=0 while rst_i is high.
  - An in-flight beat is discarded; no partial state survives reset.
- Input handshake:
  - ready_o = ~rst_i & (~full_r | ready_i[sel_r]).
  - ready_o is combinational; there is no combinational path from valid_i to ready_o.
  - accept = valid_i & ready_o.
  - pop = full_r & ready_i[sel_r].
- Register update each clock:
  - If accept: data_r<=data_i, sel_r<=select_i, full_r<=1.
  - Else if pop: full_r<=0; data_r and sel_r hold.
  - Simultaneous pop and accept: the new beat replaces the old one and full_r stays 1. Throughput is 1 beat/cycle, including when successive beats change destination.
- Outputs:
  - valid_o[k] = full_r & (sel_r==k); at most one bit is set.
  - data_k_o = data_r when sel_r==k and full_r, else 0.
  - Latency: a beat accepted at edge N is visible on channel sel at edge N (registered output), i.e. one cycle after it was presented.
- Stability: while valid_o[k]=1 and ready_i[k]=0, data_k_o and valid_o hold unchanged. Input beats are back-pressured (ready_o=0) until the beat is taken.
- Non-selected ready_i bits are ignored and have no effect on state.
- valid_i=0: no state change except a pop.
- X on select_i while valid_i=0 must not propagate into state.

Optional Feature:
- Macro: DEMUX_8_STREAM_PKT_LOCK_EN.
- Defined:
  - Adds ports last_i (input, 1) and last_o (output, 8). last_o[k] = full_r & (sel_r==k) & last_r.
  - Adds a two-state FSM, IDLE and LOCKED, with lock_sel (3 bits).
  - IDLE: an accepted beat routes by select_i. If last_i=0, the FSM goes to LOCKED with lock_sel<=select_i. If last_i=1, it stays IDLE (single-beat packet).
  - LOCKED: accepted beats route to lock_sel and select_i is ignored. An accepted beat with last_i=1 returns the FSM to IDLE.
  - Reset forces IDLE and lock_sel=0.
  - last_r is registered alongside data_r.
- Not defined: no last ports and no FSM; every beat routes independently by select_i.

Test Plan:
1. Reset, then valid_i=1, select_i=5, data_i=8'hA5, all ready_i=1 -> next cycle valid_o=8'h20, data_5_o=8'hA5, other data outputs 0; ready_o stays 1.
2. Back-to-back stream of 8 beats, select_i=0..7, data_i=8'h10+k, ready_i=8'hFF -> one beat per cycle on valid_o bits 0..7 in order; ready_o never drops.
3. Beat to channel 3 with ready_i[3]=0 for 4 cycles, and a second beat pending -> valid_o=8'h08 and data_3_o held for 4 cycles; ready_o=0. When ready_i[3] rises, the second beat loads in the same cycle (pop plus accept).
4. Channel 2 holding with ready_i[2]=0 and ready_i[6]=1 toggling -> no change in state; ready_o stays 0.
5. rst_i asserted while full_r=1 on channel 4 -> next cycle valid_o=0, data_4_o=0, ready_o=0; after release, a fresh beat routes normally.
6. (PKT_LOCK_EN) 3-beat packet: first beat select_i=1 with last_i=0, then select_i=6 and 7 with last on the third beat -> all three beats appear on channel 1 with last_o=8'h02 on beat 3. A following beat with select_i=6 goes to channel 6.
